kcpsmx_alu_seq: RTL and testbench

//  Registered, width-parametrised successor of the KCPSMX ALU for the pipelined core: executes one ALU op per accepted

---
 rtl/kcpsmx3_inc.sv | 35 +++
 rtl/kcpsmx_alu_mul_iter.sv | 62 ++++++
 rtl/kcpsmx_alu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_kcpsmx_alu_seq.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kcpsmx3_inc.sv
// kcpsmx3_inc: shared opcode/shift encodings and width default for the KCPSMX execute-stage ALU.
package kcpsmx3_inc;

   localparam int unsigned OPERAND_WIDTH_DEFAULT = 8;

   typedef enum logic [3:0] {
      OpLoad      = 4'd0,
      OpAdd       = 4'd1,
      OpAddcy     = 4'd2,
      OpSub       = 4'd3,
      OpSubcy     = 4'd4,
      OpCompare   = 4'd5,
      OpComparecy = 4'd6,
      OpAnd       = 4'd7,
      OpOr        = 4'd8,
      OpXor       = 4'd9,
      OpTest      = 4'd10,
      OpTestcy    = 4'd11,
      OpRs        = 4'd12,
      OpMul       = 4'd13
   } opcode_t;

   typedef enum logic [1:0] {
      ShRrSlx = 2'd0,
      ShRlSrx = 2'd1,
      ShSa    = 2'd2,
      ShSc    = 2'd3
   } shift_op_t;

   typedef enum logic {
      StIdle = 1'b0,
      StBusy = 1'b1
   } mul_state_t;

endpackage

// File: rtl/kcpsmx_alu_mul_iter.sv
// kcpsmx_alu_mul_iter: unsigned shift-add multiplier, one multiplier bit per clock.
// start consumes bit 0; done marks the cycle whose closing edge completes the product.
module kcpsmx_alu_mul_iter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 active,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] acc_sum;
   logic [CntW-1:0]    count_q, count_d;

   always_comb begin
      acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
      mplier_d = mplier_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      count_d  = count_q;
      if (start) begin
         acc_d    = a[0] ? {{WIDTH{1'b0}}, b} : '0;
         mplier_d = a >> 1;
         mcand_d  = {{WIDTH{1'b0}}, b} << 1;
         count_d  = CntW'(1);
      end else if (active) begin
         acc_d    = acc_sum;
         mplier_d = mplier_q >> 1;
         mcand_d  = mcand_q << 1;
         count_d  = count_q + 1'b1;
      end
   end

   // The final partial product is taken straight from the adder so the
   // top can register it on the same edge the last bit is consumed.
   assign done    = active & (count_q == CntW'(WIDTH - 1));
   assign product = acc_sum;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mplier_q <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         mplier_q <= mplier_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/kcpsmx_alu_seq.sv
// kcpsmx_alu_seq: registered KCPSMX ALU owning the C/Z flags and their interrupt shadow.
// Define KCPSMX_ALU_MUL_EN to add the iterative MUL (kcpsmx_alu_mul_iter) and its busy FSM.
module kcpsmx_alu_seq
   import kcpsmx3_inc::*;
#(
   parameter int unsigned OPERAND_WIDTH = OPERAND_WIDTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  opcode_t                  operation,
   input  shift_op_t                shift_operation,
   input  logic                     shift_direction,
   input  logic                     shift_constant,
   input  logic [OPERAND_WIDTH-1:0] operand_a,
   input  logic [OPERAND_WIDTH-1:0] operand_b,
   input  logic                     flag_we,
   input  logic                     flag_save,
   input  logic                     flag_restore,
   output logic                     out_valid,
   output logic [OPERAND_WIDTH-1:0] result,
   output logic [OPERAND_WIDTH-1:0] result_hi,
   output logic                     carry_flag,
   output logic                     zero_flag
);

   localparam int unsigned W = OPERAND_WIDTH;

   logic         carry_q, carry_d, zero_q, zero_d;
   logic         shadow_c_q, shadow_c_d, shadow_z_q, shadow_z_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] result_q, result_d;

   logic [W-1:0] alu_res;
   logic [W:0]   sum;
   logic         alu_c, alu_z, shift_bit, sub_cin, add_cin;

   logic accept, alu_done, op_flag_wr, op_c, op_z;

   always_comb begin
      alu_res   = operand_b;
      alu_c     = 1'b0;
      sum       = '0;
      add_cin   = (operation == OpAddcy) & carry_q;
      sub_cin   = ((operation == OpSubcy) || (operation == OpComparecy)) ? ~carry_q : 1'b1;
      case (shift_operation)
         ShRrSlx: shift_bit = operand_a[0];
         ShRlSrx: shift_bit = operand_a[W-1];
         ShSa:    shift_bit = carry_q;
         default: shift_bit = shift_constant;
      endcase
      case (operation)
         OpAdd, OpAddcy: begin
            sum     = {1'b0, operand_a} + {1'b0, operand_b} + {{W{1'b0}}, add_cin};
            alu_res = sum[W-1:0];
            alu_c   = sum[W];
         end
         // Carry out of a + ~b + cin is the inverted borrow.
         OpSub, OpSubcy, OpCompare, OpComparecy: begin
            sum     = {1'b0, operand_a} + {1'b0, ~operand_b} + {{W{1'b0}}, sub_cin};
            alu_res = sum[W-1:0];
            alu_c   = ~sum[W];
         end
         OpAnd: alu_res = operand_a & operand_b;
         OpOr:  alu_res = operand_a | operand_b;
         OpXor: alu_res = operand_a ^ operand_b;
         OpTest: begin
            alu_res = operand_a & operand_b;
            alu_c   = ^(operand_a & operand_b);
         end
         OpTestcy: begin
            alu_res = operand_a & operand_b;
            alu_c   = ^(operand_a & operand_b) ^ carry_q;
         end
         OpRs: begin
            if (shift_direction) begin
               alu_res = {shift_bit, operand_a[W-1:1]};
               alu_c   = operand_a[0];
            end else begin
               alu_res = {operand_a[W-2:0], shift_bit};
               alu_c   = operand_a[W-1];
            end
         end
         default: ;
      endcase
      // Chained ops only report zero if the lower-order word was zero too.
      alu_z = (alu_res == '0) &
              (((operation == OpComparecy) || (operation == OpTestcy)) ? zero_q : 1'b1);
   end

`ifdef KCPSMX_ALU_MUL_EN
   mul_state_t     state_q, state_d;
   logic           mul_start, mul_done, mul_flag_we_q;
   logic [2*W-1:0] mul_product;
   logic [W-1:0]   result_hi_q, result_hi_d;

   assign in_ready   = (state_q == StIdle);
   assign accept     = in_valid & in_ready;
   assign mul_start  = accept & (operation == OpMul);
   assign alu_done   = accept & (operation != OpMul);
   assign op_flag_wr = (alu_done & flag_we) | (mul_done & mul_flag_we_q);
   assign op_c       = mul_done ? |mul_product[2*W-1:W] : alu_c;
   assign op_z       = mul_done ? (mul_product == '0) : alu_z;
   assign result_hi  = result_hi_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (mul_start) state_d = StBusy;
         StBusy:  if (mul_done)  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   kcpsmx_alu_mul_iter #(
      .WIDTH(W)
   ) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start),
      .active  (state_q == StBusy),
      .a       (operand_a),
      .b       (operand_b),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      result_hi_d = result_hi_q;
      if (alu_done) begin
         result_hi_d = '0;
      end else if (mul_done) begin
         result_hi_d = mul_product[2*W-1:W];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         mul_flag_we_q <= 1'b0;
         result_hi_q   <= '0;
      end else begin
         state_q     <= state_d;
         result_hi_q <= result_hi_d;
         if (mul_start) begin
            mul_flag_we_q <= flag_we;
         end
      end
   end
`else
   assign in_ready   = 1'b1;
   assign accept     = in_valid;
   assign alu_done   = accept;
   assign op_flag_wr = alu_done & flag_we;
   assign op_c       = alu_c;
   assign op_z       = alu_z;
   assign result_hi  = '0;
`endif

   always_comb begin
      out_valid_d = alu_done;
      result_d    = result_q;
      if (alu_done) begin
         result_d = alu_res;
      end
`ifdef KCPSMX_ALU_MUL_EN
      if (mul_done) begin
         out_valid_d = 1'b1;
         result_d    = mul_product[W-1:0];
      end
`endif
   end

   // Shadow captures pre-update flags, so save+restore on one edge swaps them.
   always_comb begin
      shadow_c_d = flag_save ? carry_q : shadow_c_q;
      shadow_z_d = flag_save ? zero_q : shadow_z_q;
      carry_d    = carry_q;
      zero_d     = zero_q;
      if (op_flag_wr) begin
         carry_d = op_c;
         zero_d  = op_z;
      end else if (flag_restore) begin
         carry_d = shadow_c_q;
         zero_d  = shadow_z_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         shadow_c_q  <= 1'b0;
         shadow_z_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         shadow_c_q  <= shadow_c_d;
         shadow_z_q  <= shadow_z_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign result     = result_q;
   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;

endmodule

// File: tb/tb_kcpsmx_alu_seq.sv
// tb_kcpsmx_alu_seq: scoreboard bench for kcpsmx_alu_seq with an integer-arithmetic reference model.
// Covers the MUL path when KCPSMX_ALU_MUL_EN is defined, the load-path fallback otherwise.
module tb_kcpsmx_alu_seq;
   import kcpsmx3_inc::*;

   localparam int unsigned W = 8;
   localparam int Mask = (1 << W) - 1;
`ifdef KCPSMX_ALU_MUL_EN
   localparam bit MulEn = 1'b1;
`else
   localparam bit MulEn = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         c;
      logic         z;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n, in_valid, in_ready, shift_direction, shift_constant;
   logic flag_we, flag_save, flag_restore, out_valid, carry_flag, zero_flag;
   opcode_t      operation;
   shift_op_t    shift_operation;
   logic [W-1:0] operand_a, operand_b, result, result_hi;

   kcpsmx_alu_seq #(
      .OPERAND_WIDTH(W)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .operation       (operation),
      .shift_operation (shift_operation),
      .shift_direction (shift_direction),
      .shift_constant  (shift_constant),
      .operand_a       (operand_a),
      .operand_b       (operand_b),
      .flag_we         (flag_we),
      .flag_save       (flag_save),
      .flag_restore    (flag_restore),
      .out_valid       (out_valid),
      .result          (result),
      .result_hi       (result_hi),
      .carry_flag      (carry_flag),
      .zero_flag       (zero_flag)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb_q[$];
   logic mon_en = 1'b0;

   // Reference state: flags, shadow, MUL edges still to run, expected out_valid.
   logic m_c, m_z, m_sc, m_sz, m_valid, m_mul_we, m_mul_c, m_mul_z;
   int   m_busy;

   task automatic chk1(input string name, input logic act, input logic expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
   endtask

   task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
   endtask

   function automatic exp_t ref_op(input opcode_t op, input shift_op_t so, input logic dir,
                                   input logic sc, input logic [W-1:0] a_v,
                                   input logic [W-1:0] b_v, input logic c, input logic z);
      exp_t e;
      int   a, b, s, r, p;
      logic sb;
      a = int'(a_v);
      b = int'(b_v);
      e = '0;
      r = b;
      if (MulEn && op == OpMul) begin
         p     = a * b;
         e.res = W'(p);
         e.hi  = W'(p >> W);
         e.c   = (p >> W) != 0;
         e.z   = (p == 0);
         return e;
      end
      case (op)
         OpAdd, OpAddcy: begin
            s   = a + b + ((op == OpAddcy && c) ? 1 : 0);
            r   = s & Mask;
            e.c = s > Mask;
         end
         OpSub, OpSubcy, OpCompare, OpComparecy: begin
            s   = a - b - (((op == OpSubcy || op == OpComparecy) && c) ? 1 : 0);
            r   = s & Mask;
            e.c = s < 0;
         end
         OpAnd: r = a & b;
         OpOr:  r = a | b;
         OpXor: r = a ^ b;
         OpTest: begin
            r   = a & b;
            e.c = ($countones(r) % 2) == 1;
         end
         OpTestcy: begin
            r   = a & b;
            e.c = (($countones(r) + (c ? 1 : 0)) % 2) == 1;
         end
         OpRs: begin
            case (so)
               ShRrSlx: sb = a_v[0];
               ShRlSrx: sb = a_v[W-1];
               ShSa:    sb = c;
               default: sb = sc;
            endcase
            if (dir) begin
               r   = (a >> 1) + (sb ? (1 << (W - 1)) : 0);
               e.c = a_v[0];
            end else begin
               r   = ((a * 2) & Mask) + (sb ? 1 : 0);
               e.c = a_v[W-1];
            end
         end
         default: r = b;
      endcase
      e.res = W'(r);
      e.z   = (r == 0) && ((op == OpComparecy || op == OpTestcy) ? z : 1'b1);
      return e;
   endfunction

   // Drive one cycle of stimulus, then advance the model across the edge.
   task automatic cycle(input logic v, input opcode_t op, input shift_op_t so, input logic dir,
                        input logic sc, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic fwe, input logic fsv, input logic frs);
      exp_t e;
      logic acc, wr, nc, nz, pc, pz, osc, osz, mul_acc;
      in_valid = v; operation = op; shift_operation = so; shift_direction = dir;
      shift_constant = sc; operand_a = a; operand_b = b;
      flag_we = fwe; flag_save = fsv; flag_restore = frs;
      @(posedge clk);
      acc = v && (m_busy == 0);
      pc = m_c; pz = m_z; osc = m_sc; osz = m_sz;
      wr = 1'b0; nc = 1'b0; nz = 1'b0; mul_acc = 1'b0; m_valid = 1'b0;
      e = ref_op(op, so, dir, sc, a, b, pc, pz);
      if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            m_valid = 1'b1; wr = m_mul_we; nc = m_mul_c; nz = m_mul_z;
         end
      end else if (acc) begin
         if (MulEn && op == OpMul) begin
            mul_acc = 1'b1; m_busy = W - 1; m_mul_we = fwe; m_mul_c = e.c; m_mul_z = e.z;
         end else begin
            m_valid = 1'b1; wr = fwe; nc = e.c; nz = e.z;
         end
      end
      if (fsv) begin
         m_sc = pc; m_sz = pz;
      end
      if (wr) begin
         m_c = nc; m_z = nz;
      end else if (frs) begin
         m_c = osc; m_z = osz;
      end
      if (acc) begin
         if (!(mul_acc && fwe)) begin
            e.c = m_c; e.z = m_z;
         end
         sb_q.push_back(e);
      end
      #1;
   endtask

   task automatic op_do(input opcode_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic fwe, input logic frs);
      cycle(1'b1, op, ShSc, 1'b0, 1'b0, a, b, fwe, 1'b0, frs);
   endtask

   task automatic idle(input logic fsv, input logic frs);
      cycle(1'b0, OpLoad, ShSc, 1'b0, 1'b0, '0, '0, 1'b0, fsv, frs);
   endtask

   task automatic model_reset();
      m_c = 1'b0; m_z = 1'b0; m_sc = 1'b0; m_sz = 1'b0;
      m_valid = 1'b0; m_busy = 0; m_mul_we = 1'b0; m_mul_c = 1'b0; m_mul_z = 1'b0;
      sb_q.delete();
   endtask

   task automatic chk_reset_state();
      chk1("rst_out_valid", out_valid, 1'b0);
      chkw("rst_result", result, '0);
      chkw("rst_result_hi", result_hi, '0);
      chk1("rst_carry", carry_flag, 1'b0);
      chk1("rst_zero", zero_flag, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (mon_en) begin
         chk1("in_ready", in_ready, m_busy == 0);
         chk1("out_valid", out_valid, m_valid);
         chk1("carry_flag", carry_flag, m_c);
         chk1("zero_flag", zero_flag, m_z);
         if (out_valid && m_valid) begin
            if (sb_q.size() == 0) begin
               chk1("sb_nonempty", 1'b0, 1'b1);
            end else begin
               mon_e = sb_q.pop_front();
               chkw("sb_result", result, mon_e.res);
               chkw("sb_result_hi", result_hi, mon_e.hi);
               chk1("sb_carry", carry_flag, mon_e.c);
               chk1("sb_zero", zero_flag, mon_e.z);
            end
         end
      end
   end

   logic busy, rsv, rrs;
   initial begin
      model_reset();
      reset_n = 1'b0; in_valid = 1'b0; operation = OpLoad; shift_operation = ShSc;
      shift_direction = 1'b0; shift_constant = 1'b0; operand_a = '0; operand_b = '0;
      flag_we = 1'b0; flag_save = 1'b0; flag_restore = 1'b0;
      #12;
      chk_reset_state();
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      mon_en = 1'b1;
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);

      op_do(OpAdd, 8'hFF, 8'h01, 1'b1, 1'b0);
      chkw("add_ff01_res", result, 8'h00);
      chk1("add_ff01_c", carry_flag, 1'b1);
      chk1("add_ff01_z", zero_flag, 1'b1);
      op_do(OpAddcy, 8'h00, 8'h00, 1'b1, 1'b0);
      chkw("addcy_res", result, 8'h01);
      chk1("addcy_c", carry_flag, 1'b0);
      chk1("addcy_z", zero_flag, 1'b0);

      op_do(OpSub, 8'h10, 8'h20, 1'b1, 1'b0);
      chkw("sub_res", result, 8'hF0);
      chk1("sub_c", carry_flag, 1'b1);
      op_do(OpCompare, 8'h34, 8'h34, 1'b1, 1'b0);
      op_do(OpComparecy, 8'h12, 8'h12, 1'b1, 1'b0);
      chk1("cmpcy_eq_z", zero_flag, 1'b1);
      chk1("cmpcy_eq_c", carry_flag, 1'b0);
      op_do(OpComparecy, 8'h12, 8'h13, 1'b1, 1'b0);
      chk1("cmpcy_lt_c", carry_flag, 1'b1);
      chk1("cmpcy_lt_z", zero_flag, 1'b0);

      op_do(OpTest, 8'h03, 8'h01, 1'b1, 1'b0);
      chk1("test_c", carry_flag, 1'b1);
      chk1("test_z", zero_flag, 1'b0);
      op_do(OpTestcy, 8'h01, 8'h01, 1'b1, 1'b0);
      chk1("testcy_c", carry_flag, 1'b0);
      op_do(OpXor, 8'h5A, 8'h5A, 1'b0, 1'b0);
      chk1("nowe_c", carry_flag, 1'b0);
      chk1("nowe_z", zero_flag, 1'b0);

      op_do(OpTest, 8'h03, 8'h01, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      op_do(OpAdd, 8'h00, 8'h00, 1'b1, 1'b0);
      chk1("pre_rest_c", carry_flag, 1'b0);
      chk1("pre_rest_z", zero_flag, 1'b1);
      idle(1'b0, 1'b1);
      chk1("restore_c", carry_flag, 1'b1);
      chk1("restore_z", zero_flag, 1'b0);
      op_do(OpAdd, 8'h01, 8'h01, 1'b1, 1'b1);
      chk1("rest_op_wins_c", carry_flag, 1'b0);

      op_do(OpMul, 8'h0F, 8'h11, 1'b1, 1'b0);
`ifdef KCPSMX_ALU_MUL_EN
      chk1("mul_busy_ready", in_ready, 1'b0);
      repeat (W - 1) idle(1'b0, 1'b0);
      chkw("mul_0f11_res", result, 8'hFF);
      chkw("mul_0f11_hi", result_hi, 8'h00);
      chk1("mul_0f11_c", carry_flag, 1'b0);
      op_do(OpMul, 8'hFF, 8'hFF, 1'b1, 1'b0);
      repeat (W - 1) idle(1'b0, 1'b0);
      chkw("mul_ffff_res", result, 8'h01);
      chkw("mul_ffff_hi", result_hi, 8'hFE);
      chk1("mul_ffff_c", carry_flag, 1'b1);
`else
      chkw("mul_load_res", result, 8'h11);
      chkw("mul_load_hi", result_hi, 8'h00);
      chk1("mul_load_c", carry_flag, 1'b0);
`endif

      // Reset pulse while a MUL is in flight (or just after a load-path MUL).
      op_do(OpAdd, 8'hFF, 8'h01, 1'b1, 1'b0);
      op_do(OpMul, 8'hFF, 8'hFF, 1'b1, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      mon_en = 1'b0;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk_reset_state();
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      mon_en = 1'b1;
      repeat (W + 1) idle(1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         busy = (m_busy != 0);
         rsv = !busy && ($urandom_range(0, 3) == 0);
         rrs = !busy && ($urandom_range(0, 3) == 0);
         cycle($urandom_range(0, 3) != 0, opcode_t'(4'($urandom_range(0, 15))),
               shift_op_t'(2'($urandom_range(0, 3))), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
               1'($urandom_range(0, 1)), rsv, rrs);
      end
      repeat (W + 1) idle(1'b0, 1'b0);
      chk1("sb_drained", sb_q.size() == 0, 1'b1);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
